// File: rtl/accum_seq_16bit_if.sv
// ----------------------------------------------------------------------------
// accum_seq_16bit_if
// Groups the burst accumulator's data and handshake signals. The producer,
// the consumer and the control side all live on the master modport. The
// accumulator itself uses the slave modport.
//
// Signals (direction seen from the slave / accumulator):
//   start     in   begin a burst (sampled only while idle)
//   len       in   operand count for the burst, CNT_W bits
//   din       in   16-bit operand
//   in_valid  in   din carries a valid operand
//   in_ready  out  accumulator takes din this cycle
//   sum       out  running / final sum modulo 2^16
//   carries   out  number of adder carry-outs seen during the burst
//   out_valid out  sum and carries hold the final result
//   out_ready in   consumer takes the result
//   busy      out  accumulator is not idle
// ----------------------------------------------------------------------------
interface accum_seq_16bit_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic [15:0]      din;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      sum;
    logic [CNT_W-1:0] carries;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, len, din, in_valid, out_ready,
        input  in_ready, sum, carries, out_valid, busy
    );

    modport slave (
        input  start, len, din, in_valid, out_ready,
        output in_ready, sum, carries, out_valid, busy
    );
endinterface

// File: rtl/accum_seq_16bit.sv
// ----------------------------------------------------------------------------
// accum_seq_16bit
// Sequential 16-bit burst accumulator. It adds each accepted operand into a
// running sum with a carry-select adder whose carry-in is 0, and it counts the
// adder's carry-outs. The exact burst total is {carries, sum}. The result is
// offered on a valid/ready handshake.
//
// Ports:
//   clk  in     single clock, rising edge
//   rst  in     asynchronous active-high reset
//   bus  slave  accum_seq_16bit_if (start/len/din/in_valid/in_ready,
//               sum/carries/out_valid/out_ready, busy)
// ----------------------------------------------------------------------------
module accum_seq_16bit #(
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    accum_seq_16bit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [15:0]      r_sum;
    logic [CNT_W-1:0] r_carries;
    logic [CNT_W-1:0] r_remaining;
    logic             r_outValid;
    logic             r_busy;

    logic [8:0]       w_loSum;
    logic [8:0]       w_hiSum0;
    logic [8:0]       w_hiSum1;
    logic [8:0]       w_hiSel;
    logic [15:0]      w_addSum;
    logic             w_addCout;
    logic             w_inReady;
    logic             w_xfer;

    // Carry-select adder, carry-in 0. The low byte ripples. The high byte is
    // computed for both possible carries and the low byte's carry-out picks
    // one. The path is purely combinational from r_sum/din back into r_sum.
    assign w_loSum   = {1'b0, r_sum[7:0]}  + {1'b0, bus.din[7:0]};
    assign w_hiSum0  = {1'b0, r_sum[15:8]} + {1'b0, bus.din[15:8]};
    assign w_hiSum1  = {1'b0, r_sum[15:8]} + {1'b0, bus.din[15:8]} + 9'd1;
    assign w_hiSel   = w_loSum[8] ? w_hiSum1 : w_hiSum0;
    assign w_addSum  = {w_hiSel[7:0], w_loSum[7:0]};
    assign w_addCout = w_hiSel[8];

    // in_ready is decoded straight from the state, so it drops in the same
    // cycle that an asynchronous reset forces the FSM back to IDLE.
    assign w_inReady = (r_state == ACCUM);
    assign w_xfer    = w_inReady && bus.in_valid;

    assign bus.in_ready  = w_inReady;
    assign bus.sum       = r_sum;
    assign bus.carries   = r_carries;
    assign bus.out_valid = r_outValid;
    assign bus.busy      = r_busy;

    // Burst control FSM with registered out_valid and busy.
    // - IDLE clears the result on start. A zero length burst jumps straight
    //   to DONE, so it never raises in_ready.
    // - ACCUM folds one operand per transfer into the sum. The transfer that
    //   consumes the last operand moves the FSM to DONE.
    // - DONE holds the result until the consumer takes it. start is not
    //   looked at here, so a start on the exit cycle is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sum       <= '0;
            r_carries   <= '0;
            r_remaining <= '0;
            r_outValid  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sum     <= '0;
                        r_carries <= '0;
                        r_busy    <= 1'b1;
                        if (bus.len != '0) begin
                            r_remaining <= bus.len;
                            r_state     <= ACCUM;
                        end else begin
                            r_outValid <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (w_xfer) begin
                        r_sum       <= w_addSum;
                        r_carries   <= r_carries + CNT_W'(w_addCout);
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_outValid <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_seq_16bit.sv
// ----------------------------------------------------------------------------
// tb_accum_seq_16bit
// Directed bench for accum_seq_16bit. Each scenario task drives its own
// stimulus and compares the outputs against hand-computed values. Inputs
// change 1 ns after a rising edge, and outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_accum_seq_16bit;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   edges    = 0;

    accum_seq_16bit_if #(.CNT_W(CNT_W)) bus ();

    accum_seq_16bit #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it; edges numbers the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    // Present start for exactly one edge.
    task automatic startBurst(input logic [CNT_W-1:0] l);
        bus.len   = l;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.len   = '0;
    endtask

    // Take the result with a single out_ready cycle.
    task automatic acceptResult();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // Outputs under reset, then still idle after release.
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.sum, bus.carries, bus.in_ready, bus.out_valid, bus.busy} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: sum=%h carries=%h in_ready=%b out_valid=%b busy=%b required all 0",
                     bus.sum, bus.carries, bus.in_ready, bus.out_valid, bus.busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_idle: busy=%b in_ready=%b required 0 0", bus.busy, bus.in_ready);
        end
    endtask

    // len=3 of 1,2,3 back-to-back.
    task automatic test_basic_burst();
        int s;
        int firstCyc;
        firstCyc = -1;
        startBurst(4'd3);
        s = edges;
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_start: busy=%b in_ready=%b required 1 1", bus.busy, bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.din      = 16'(i + 1);
            tick();
            if (bus.out_valid === 1'b1 && firstCyc < 0) firstCyc = edges - s + 1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (firstCyc !== 4) begin
            failures++;
            $display("[TB] FAIL basic_latency: out_valid at S+%0d required S+4", firstCyc);
        end
        checks++;
        if (bus.sum !== 16'h0006 || bus.carries !== 4'd0) begin
            failures++;
            $display("[TB] FAIL basic_result: sum=%h carries=%0d required 0006 0", bus.sum, bus.carries);
        end
        acceptResult();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== 16'h0006) begin
            failures++;
            $display("[TB] FAIL basic_to_idle: out_valid=%b busy=%b sum=%h required 0 0 0006",
                     bus.out_valid, bus.busy, bus.sum);
        end
    endtask

    // 0xFFFF + 0x0002 wraps with one carry.
    task automatic test_carry_capture();
        startBurst(4'd2);
        bus.in_valid = 1'b1;
        bus.din = 16'hFFFF;
        tick();
        bus.din = 16'h0002;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0001 || bus.carries !== 4'd1) begin
            failures++;
            $display("[TB] FAIL carry_result: out_valid=%b sum=%h carries=%0d required 1 0001 1",
                     bus.out_valid, bus.sum, bus.carries);
        end
        acceptResult();
    endtask

    // 15 x 0xFFFF = 0xEFFF1, so the carries field reaches 14.
    task automatic test_max_burst();
        int s;
        int firstCyc;
        firstCyc = -1;
        startBurst(4'd15);
        s = edges;
        for (int i = 0; i < 15; i++) begin
            bus.in_valid = 1'b1;
            bus.din      = 16'hFFFF;
            tick();
            if (bus.out_valid === 1'b1 && firstCyc < 0) firstCyc = edges - s + 1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (firstCyc !== 16) begin
            failures++;
            $display("[TB] FAIL max_latency: out_valid at S+%0d required S+16", firstCyc);
        end
        checks++;
        if (bus.sum !== 16'hFFF1 || bus.carries !== 4'd14) begin
            failures++;
            $display("[TB] FAIL max_result: sum=%h carries=%0d required fff1 14", bus.sum, bus.carries);
        end
        acceptResult();
    endtask

    // len=0 goes straight to DONE, clearing the previous (nonzero) result.
    task automatic test_zero_length();
        startBurst(4'd0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_flags: out_valid=%b in_ready=%b busy=%b required 1 0 1",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        checks++;
        if (bus.sum !== 16'h0000 || bus.carries !== 4'd0) begin
            failures++;
            $display("[TB] FAIL zero_result: sum=%h carries=%0d required 0000 0", bus.sum, bus.carries);
        end
        // Operands offered in DONE must be ignored.
        bus.in_valid = 1'b1;
        bus.din      = 16'h1234;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.sum !== 16'h0000 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_hold: in_ready=%b sum=%h out_valid=%b required 0 0000 1",
                     bus.in_ready, bus.sum, bus.out_valid);
        end
        acceptResult();
    endtask

    // Gapped input, stalled output, and start pulses while in DONE.
    task automatic test_backpressure();
        logic [5:0] pat;
        int xfers;
        pat   = 6'b110101;
        xfers = 0;
        startBurst(4'd4);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = pat[i];
            bus.din      = 16'h1000;
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) xfers++;
            tick();
            if (i == 4) begin
                checks++;
                if (bus.out_valid !== 1'b0 || bus.sum !== 16'h3000) begin
                    failures++;
                    $display("[TB] FAIL bp_partial: out_valid=%b sum=%h required 0 3000", bus.out_valid, bus.sum);
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (xfers !== 4 || bus.out_valid !== 1'b1 || bus.sum !== 16'h4000 || bus.carries !== 4'd0) begin
            failures++;
            $display("[TB] FAIL bp_result: xfers=%0d out_valid=%b sum=%h carries=%0d required 4 1 4000 0",
                     xfers, bus.out_valid, bus.sum, bus.carries);
        end
        for (int k = 0; k < 5; k++) begin
            bus.start    = (k == 2);
            bus.len      = 4'd3;
            bus.in_valid = 1'b1;
            bus.din      = 16'hAAAA;
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.sum !== 16'h4000 || bus.carries !== 4'd0 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_stall_%0d: out_valid=%b sum=%h carries=%0d in_ready=%b required 1 4000 0 0",
                         k, bus.out_valid, bus.sum, bus.carries, bus.in_ready);
            end
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        // start on the exit cycle must be dropped.
        bus.start     = 1'b1;
        bus.len       = 4'd2;
        bus.out_ready = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_exit_start: busy=%b out_valid=%b in_ready=%b required 0 0 0",
                     bus.busy, bus.out_valid, bus.in_ready);
        end
    endtask

    // Asynchronous reset after two transfers, then a fresh burst.
    task automatic test_reset_mid_burst();
        startBurst(4'd4);
        bus.in_valid = 1'b1;
        bus.din      = 16'h0005;
        tick();
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.sum !== 16'h000A || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midrst_before: sum=%h busy=%b required 000a 1", bus.sum, bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.sum, bus.carries, bus.in_ready, bus.out_valid, bus.busy} !== '0) begin
            failures++;
            $display("[TB] FAIL midrst_async: sum=%h carries=%h in_ready=%b out_valid=%b busy=%b required all 0",
                     bus.sum, bus.carries, bus.in_ready, bus.out_valid, bus.busy);
        end
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_idle: busy=%b out_valid=%b required 0 0", bus.busy, bus.out_valid);
        end
        startBurst(4'd2);
        bus.in_valid = 1'b1;
        bus.din = 16'h0005;
        tick();
        bus.din = 16'h0007;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 16'h000C || bus.carries !== 4'd0) begin
            failures++;
            $display("[TB] FAIL midrst_rerun: out_valid=%b sum=%h carries=%0d required 1 000c 0",
                     bus.out_valid, bus.sum, bus.carries);
        end
        acceptResult();
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.din       = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        $display("[TB] accum_seq_16bit directed tests");
        test_reset();
        test_basic_burst();
        test_carry_capture();
        test_max_burst();
        test_zero_length();
        test_backpressure();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
